// File: rtl/fft_stage_ctrl.sv
// Sequencer for an in-place radix-4 FFT: issues groups to the PE stage by stage,
// ping-pongs memory banks and tracks PE write-back with a fixed-latency delay line.
module fft_stage_ctrl #(
   parameter int LOG2N  = 4,
   parameter int PE_LAT = 3,
   parameter int NSTAGE = LOG2N - 1,
   localparam int NG    = (1 << LOG2N) / 4,
   localparam int GW    = LOG2N - 2,
   localparam int SW    = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_hold,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_rd_vld,
   output logic [GW-1:0] o_rd_grp,
   output logic          o_rd_bank,
   output logic [GW-1:0] o_tf_addr,
   output logic          o_bypass_n,
   output logic [SW-1:0] o_stage,
   output logic          o_wr_vld,
   output logic [GW-1:0] o_wr_grp,
   output logic          o_wr_bank
);

   localparam int DW = $clog2(PE_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          r_state, w_nxt_state;
   logic [GW-1:0]   r_cnt, w_nxt_cnt;
   logic [SW-1:0]   r_stage, w_nxt_stage;
   logic [DW-1:0]   r_dcnt, w_nxt_dcnt;
   logic            w_issue;
   logic [GW-1:0]   w_grp;

   logic            r_busy, r_done, r_rd_vld, r_rd_bank, r_bypass_n;
   logic [GW-1:0]   r_rd_grp, r_tf_addr;
   logic            w_nxt_busy, w_nxt_done, w_nxt_bypass_n;
   logic [GW-1:0]   w_nxt_rd_grp, w_nxt_tf_addr;

   logic [PE_LAT-1:0]         r_vld_pipe;
   logic [PE_LAT-1:0]         r_bank_pipe;
   logic [PE_LAT-1:0][GW-1:0] r_grp_pipe;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_stage <= '0;
         r_dcnt  <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_stage <= w_nxt_stage;
         r_dcnt  <= w_nxt_dcnt;
      end
   end

   // Issue decisions are made one edge ahead so rd_* can be registered outputs;
   // the transition into a RUN pass carries the first issue of that pass.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_stage = r_stage;
      w_nxt_dcnt  = r_dcnt;
      w_issue     = 1'b0;
      w_grp       = r_cnt;
      case (r_state)
         S_IDLE: if (i_start) begin
            w_nxt_state = S_RUN;
            w_nxt_stage = '0;
            w_grp       = '0;
            w_issue     = !i_hold;
            w_nxt_cnt   = i_hold ? GW'(0) : GW'(1);
         end
         S_RUN: if (!i_hold) begin
            w_issue   = 1'b1;
            w_nxt_cnt = r_cnt + GW'(1);
            if (r_cnt == GW'(NG - 1)) begin
               w_nxt_state = S_DRAIN;
               w_nxt_dcnt  = '0;
            end
         end
         S_DRAIN: begin
            if (r_dcnt == DW'(PE_LAT)) begin
               if (r_stage < SW'(NSTAGE - 1)) begin
                  w_nxt_state = S_RUN;
                  w_nxt_stage = r_stage + SW'(1);
                  w_grp       = '0;
                  w_issue     = !i_hold;
                  w_nxt_cnt   = i_hold ? GW'(0) : GW'(1);
               end else begin
                  w_nxt_state = S_DONE;
               end
            end else begin
               w_nxt_dcnt = r_dcnt + DW'(1);
            end
         end
         S_DONE:  w_nxt_state = S_IDLE;
         default: w_nxt_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_nxt_busy     = (w_nxt_state != S_IDLE);
      w_nxt_done     = (w_nxt_state == S_DONE);
      w_nxt_bypass_n = (w_nxt_stage != SW'(NSTAGE - 1));
      w_nxt_rd_grp   = r_rd_grp;
      w_nxt_tf_addr  = r_tf_addr;
      if (w_issue) begin
         w_nxt_rd_grp  = w_grp;
         w_nxt_tf_addr = w_grp << w_nxt_stage;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rd_vld    <= 1'b0;
         r_rd_grp    <= '0;
         r_tf_addr   <= '0;
         r_rd_bank   <= 1'b0;
         r_bypass_n  <= 1'b1;
         r_vld_pipe  <= '0;
         r_bank_pipe <= '0;
         r_grp_pipe  <= '0;
      end else begin
         r_busy         <= w_nxt_busy;
         r_done         <= w_nxt_done;
         r_rd_vld       <= w_issue;
         r_rd_grp       <= w_nxt_rd_grp;
         r_tf_addr      <= w_nxt_tf_addr;
         r_rd_bank      <= w_nxt_stage[0];
         r_bypass_n     <= w_nxt_bypass_n;
         r_vld_pipe[0]  <= r_rd_vld;
         r_grp_pipe[0]  <= r_rd_grp;
         r_bank_pipe[0] <= ~r_rd_bank;
         for (int k = 1; k < PE_LAT; k++) begin
            r_vld_pipe[k]  <= r_vld_pipe[k-1];
            r_grp_pipe[k]  <= r_grp_pipe[k-1];
            r_bank_pipe[k] <= r_bank_pipe[k-1];
         end
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_rd_vld   = r_rd_vld;
   assign o_rd_grp   = r_rd_grp;
   assign o_rd_bank  = r_rd_bank;
   assign o_tf_addr  = r_tf_addr;
   assign o_bypass_n = r_bypass_n;
   assign o_stage    = r_stage;
   assign o_wr_vld   = r_vld_pipe[PE_LAT-1];
   assign o_wr_grp   = r_grp_pipe[PE_LAT-1];
   assign o_wr_bank  = r_bank_pipe[PE_LAT-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl (LOG2N=4, PE_LAT=3): nominal, hold, busy-start
// and mid-run reset scenarios against hand-derived issue/write-back timelines.
module tb_fft_stage_ctrl;
   logic       clk = 1'b0;
   logic       rst, start, hold;
   logic       busy, done, rd_vld, rd_bank, bypass_n, wr_vld, wr_bank;
   logic [1:0] rd_grp, tf_addr, stage, wr_grp;

   int nassert = 0;
   int nfail   = 0;
   bit ev [0:39];
   int eg [0:39];
   int es [0:39];
   bit hh [0:39];

   fft_stage_ctrl #(.LOG2N(4), .PE_LAT(3)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_hold(hold),
      .o_busy(busy), .o_done(done), .o_rd_vld(rd_vld), .o_rd_grp(rd_grp),
      .o_rd_bank(rd_bank), .o_tf_addr(tf_addr), .o_bypass_n(bypass_n),
      .o_stage(stage), .o_wr_vld(wr_vld), .o_wr_grp(wr_grp), .o_wr_bank(wr_bank)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s cycle %0d: got %0h expected %0h", tag, c, obs, exp);
      end
   endtask

   task automatic chk_reset(input int c);
      chk("rst_busy", c, 32'(busy), 0);
      chk("rst_done", c, 32'(done), 0);
      chk("rst_rd_vld", c, 32'(rd_vld), 0);
      chk("rst_wr_vld", c, 32'(wr_vld), 0);
      chk("rst_rd_grp", c, 32'(rd_grp), 0);
      chk("rst_tf_addr", c, 32'(tf_addr), 0);
      chk("rst_stage", c, 32'(stage), 0);
      chk("rst_rd_bank", c, 32'(rd_bank), 0);
      chk("rst_wr_bank", c, 32'(wr_bank), 0);
      chk("rst_bypass_n", c, 32'(bypass_n), 1);
   endtask

   task automatic clear_tables();
      for (int i = 0; i < 40; i++) begin
         ev[i] = 1'b0; eg[i] = 0; es[i] = 0; hh[i] = 1'b0;
      end
   endtask

   task automatic put_stage(input int c0, input int st);
      for (int g = 0; g < 4; g++) begin
         ev[c0+g] = 1'b1; eg[c0+g] = g; es[c0+g] = st;
      end
   endtask

   // Caller has already put start=1 for cycle 0; this walks cycles 1..last.
   task automatic run_check(input int done_at, input int glitch_cyc);
      int wc;
      for (int c = 1; c <= done_at + 2; c++) begin
         step();
         start = (c == glitch_cyc);
         hold  = hh[c];
         chk("busy", c, 32'(busy), 32'(c <= done_at));
         chk("done", c, 32'(done), 32'(c == done_at));
         chk("rd_vld", c, 32'(rd_vld), 32'(ev[c]));
         if (ev[c]) begin
            chk("rd_grp", c, 32'(rd_grp), eg[c]);
            chk("stage", c, 32'(stage), es[c]);
            chk("tf_addr", c, 32'(tf_addr), (eg[c] << es[c]) & 3);
            chk("bypass_n", c, 32'(bypass_n), 32'(es[c] != 2));
            chk("rd_bank", c, 32'(rd_bank), es[c] & 1);
         end
         wc = (c >= 3) ? c - 3 : 0;
         chk("wr_vld", c, 32'(wr_vld), 32'((c >= 3) && ev[wc]));
         if (c >= 3 && ev[wc]) begin
            chk("wr_grp", c, 32'(wr_grp), eg[wc]);
            chk("wr_bank", c, 32'(wr_bank), 1 - (es[wc] & 1));
         end
      end
      start = 1'b0;
      hold  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; hold = 1'b0;
      step(); step();
      chk_reset(-1);
      rst = 1'b0;
      step();

      // Nominal run, plus a start pulse at cycle 5 that must be ignored.
      clear_tables();
      put_stage(1, 0); put_stage(8, 1); put_stage(15, 2);
      start = 1'b1;
      run_check(22, 5);
      step(); step();

      // hold over the issue slots of cycles 2-3 shifts everything by two cycles.
      clear_tables();
      ev[1] = 1; eg[1] = 0;
      ev[4] = 1; eg[4] = 1;
      ev[5] = 1; eg[5] = 2;
      ev[6] = 1; eg[6] = 3;
      put_stage(10, 1); put_stage(17, 2);
      hh[1] = 1; hh[2] = 1;
      start = 1'b1;
      run_check(24, -1);
      step(); step();

      // Reset at cycle 10 of a run: in-flight write-backs must vanish.
      start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         step();
         start = 1'b0;
      end
      chk("pre_rst_rd_vld", 10, 32'(rd_vld), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset(11);
      for (int c = 12; c <= 16; c++) begin
         step();
         chk("post_rst_wr_vld", c, 32'(wr_vld), 0);
         chk("post_rst_busy", c, 32'(busy), 0);
      end

      // start coincident with reset is dropped.
      start = 1'b1; rst = 1'b1;
      step();
      start = 1'b0; rst = 1'b0;
      chk("start_in_rst_busy", 0, 32'(busy), 0);
      step();
      chk("start_in_rst_busy2", 1, 32'(busy), 0);

      // Fresh full run after reset.
      clear_tables();
      put_stage(1, 0); put_stage(8, 1); put_stage(15, 2);
      start = 1'b1;
      run_check(22, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end
endmodule
